// File: rtl/instruction_encoder_pkg.sv
// Shared types and field layout for the instruction encoder.
// Optional build macro ENCODER_RANGE_CHECK_EN enables operand range rejection.
package instruction_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_F42  = 2'd0,
    FMT_F51  = 2'd1,
    FMT_F6   = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OPC_MSB   = 9;
  localparam int OPC_LSB   = 6;
  localparam int FIELD_MSB = 5;
  localparam int WORD_W    = OPC_MSB + 1;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational packing of instruction fields into a 10-bit word.
// With ENCODER_RANGE_CHECK_EN, oversized operands are flagged for rejection.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  fmt_e              fmt_i,
  input  logic [15:0]       operand_i,
  input  logic [1:0]        flags_i,
  output logic [WORD_W-1:0] word_o,
  output logic              rej_o
);

`ifndef ENCODER_RANGE_CHECK_EN
  logic unused_hi;
  assign unused_hi = ^operand_i[15:6];
`endif

  always_comb begin
    word_o = '0;
    rej_o  = 1'b0;
    word_o[OPC_MSB:OPC_LSB] = opcode_i;
    unique case (fmt_i)
      FMT_F42: begin
        word_o[FIELD_MSB:0] = {operand_i[3:0], flags_i};
`ifdef ENCODER_RANGE_CHECK_EN
        rej_o = |operand_i[15:4];
`endif
      end
      FMT_F51: begin
        word_o[FIELD_MSB:0] = {operand_i[4:0], flags_i[0]};
`ifdef ENCODER_RANGE_CHECK_EN
        rej_o = (|operand_i[15:5]) | flags_i[1];
`endif
      end
      FMT_F6: begin
        word_o[FIELD_MSB:0] = operand_i[5:0];
`ifdef ENCODER_RANGE_CHECK_EN
        rej_o = |operand_i[15:6];
`endif
      end
      default: rej_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Loads encoded instruction words sequentially into instruction memory.
// Build macro ENCODER_RANGE_CHECK_EN selects operand range rejection.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3:0]        Opcode,
  input  logic [1:0]        Format,
  input  logic [15:0]       Operand,
  input  logic [1:0]        Flags,
  input  logic              Last,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [WORD_W-1:0] MemData,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, waddr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [WORD_W-1:0]   wdata_q, word;
  logic                err_q, we_q;
  logic                rej, xfer, wr, fill_wr;

  instr_pack u_pack (
    .opcode_i  (Opcode),
    .fmt_i     (fmt_e'(Format)),
    .operand_i (Operand),
    .flags_i   (Flags),
    .word_o    (word),
    .rej_o     (rej)
  );

  assign xfer    = InValid & InReady;
  assign wr      = xfer & ~rej;
  assign fill_wr = wr && (cnt_q == DEPTH_C - 1'b1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Start)
      state_d = LOAD;
    else if (state_q == LOAD && xfer && (Last || fill_wr))
      state_d = DONE;
  end

  // Start masks InReady so a coincident transfer is dropped.
  always_comb begin
    InReady = (state_q == LOAD) && (cnt_q < DEPTH_C) && !Start;
    Busy    = (state_q == LOAD);
    Done    = (state_q == DONE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= wr;
      if (Start) begin
        addr_q <= '0;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else if (xfer) begin
        if (rej) begin
          err_q <= 1'b1;
        end else begin
          addr_q  <= addr_q + 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          waddr_q <= addr_q;
          wdata_q <= word;
        end
      end
    end
  end

  assign MemWe   = we_q;
  assign MemAddr = waddr_q;
  assign MemData = wdata_q;
  assign Count   = cnt_q;
  assign Error   = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: vector table, directed sequences and a random run
// against a session-level reference model.
module tb_instruction_encoder;

  localparam int DEP = 256;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start, InValid, Last;
  logic [3:0]  Opcode;
  logic [1:0]  Format, Flags;
  logic [15:0] Operand;
  logic        InReady, MemWe, Busy, Done, Error;
  logic [7:0]  MemAddr;
  logic [9:0]  MemData;
  logic [8:0]  Count;

  logic        d4_Start, d4_InValid, d4_Last;
  logic [3:0]  d4_Opcode;
  logic [1:0]  d4_Format, d4_Flags;
  logic [15:0] d4_Operand;
  logic        d4_InReady, d4_MemWe, d4_Busy, d4_Done, d4_Error;
  logic [7:0]  d4_MemAddr;
  logic [9:0]  d4_MemData;
  logic [8:0]  d4_Count;

  always #5 Clock = ~Clock;

  instruction_encoder dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start),
    .InValid(InValid), .InReady(InReady), .Opcode(Opcode),
    .Format(Format), .Operand(Operand), .Flags(Flags),
    .Last(Last), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemData(MemData), .Count(Count), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  instruction_encoder #(.ADDR_W(8), .DEPTH(4)) dut4 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(d4_Start),
    .InValid(d4_InValid), .InReady(d4_InReady), .Opcode(d4_Opcode),
    .Format(d4_Format), .Operand(d4_Operand), .Flags(d4_Flags),
    .Last(d4_Last), .MemWe(d4_MemWe), .MemAddr(d4_MemAddr),
    .MemData(d4_MemData), .Count(d4_Count), .Busy(d4_Busy),
    .Done(d4_Done), .Error(d4_Error)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Reference model: session flags, word count, error, last write.
  bit m_load, m_done, m_err, m_we;
  int m_cnt, m_waddr, m_wdata;

  function automatic bit is_rej(int f, int operand, int fl);
    if (f == 3) return 1'b1;
`ifdef ENCODER_RANGE_CHECK_EN
    if (f == 0 && operand > 15) return 1'b1;
    if (f == 1 && (operand > 31 || fl > 1)) return 1'b1;
    if (f == 2 && operand > 63) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int enc(int f, int op, int operand, int fl);
    case (f)
      0:       return op * 64 + (operand % 16) * 4 + fl;
      1:       return op * 64 + (operand % 32) * 2 + (fl % 2);
      default: return op * 64 + (operand % 64);
    endcase
  endfunction

  task automatic m_reset();
    m_load = 0; m_done = 0; m_err = 0; m_we = 0; m_cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, MemWe, 0);
    chk({tag, "_addr"}, MemAddr, 0);
    chk({tag, "_data"}, MemData, 0);
    chk({tag, "_count"}, Count, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_error"}, Error, 0);
    chk({tag, "_ready"}, InReady, 0);
  endtask

  // One clock cycle: drive, check InReady, advance model, check outputs.
  task automatic cyc(input bit st, input bit v, input int f, input int op,
                     input int operand, input int fl, input bit last);
    bit ready;
    Start = st; InValid = v; Format = f[1:0]; Opcode = op[3:0];
    Operand = operand[15:0]; Flags = fl[1:0]; Last = last;
    #1;
    ready = m_load && (m_cnt < DEP) && !st;
    chk("in_ready", InReady, ready);
    m_we = 0;
    if (st) begin
      m_load = 1; m_done = 0; m_cnt = 0; m_err = 0;
    end else if (ready && v) begin
      if (is_rej(f, operand, fl)) begin
        m_err = 1;
      end else begin
        m_we = 1;
        m_waddr = m_cnt % 256;
        m_wdata = enc(f, op, operand, fl);
        m_cnt++;
      end
      if (last || m_cnt == DEP) begin
        m_load = 0; m_done = 1;
      end
    end
    @(posedge Clock); #1;
    Start = 0; InValid = 0; Last = 0;
    chk("mem_we", MemWe, m_we);
    chk("count", Count, m_cnt);
    chk("error", Error, m_err);
    chk("busy", Busy, m_load);
    chk("done", Done, m_done);
    if (m_we) begin
      chk("mem_addr", MemAddr, m_waddr);
      chk("mem_data", MemData, m_wdata);
    end
  endtask

  typedef struct {
    int f; int op; int operand; int fl; int word; bit rej;
  } vec_t;
  vec_t vt[8];

  initial begin
    int ops[3];
    Reset_n = 0; Start = 0; InValid = 0; Last = 0;
    Opcode = 0; Format = 0; Operand = 0; Flags = 0;
    d4_Start = 0; d4_InValid = 0; d4_Last = 0;
    d4_Opcode = 0; d4_Format = 0; d4_Operand = 0; d4_Flags = 0;
    m_reset();

    vt[0] = '{0, 10, 5, 2, 10'h296, 0};
    vt[1] = '{1, 3, 19, 1, 10'h0E7, 0};
    vt[2] = '{2, 15, 42, 0, 10'h3EA, 0};
    vt[3] = '{3, 1, 0, 0, 0, 1};
    vt[7] = '{2, 0, 63, 0, 10'h03F, 0};
`ifdef ENCODER_RANGE_CHECK_EN
    vt[4] = '{1, 2, 32, 0, 0, 1};
    vt[5] = '{0, 0, 19, 3, 0, 1};
    vt[6] = '{1, 5, 1, 2, 0, 1};
`else
    vt[4] = '{1, 2, 32, 0, 10'h080, 0};
    vt[5] = '{0, 0, 19, 3, 10'h00F, 0};
    vt[6] = '{1, 5, 1, 2, 10'h142, 0};
`endif

    #12;
    chk_zero("reset");
    @(posedge Clock); #1;
    Reset_n = 1;

    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, vt[i].f, vt[i].op, vt[i].operand, vt[i].fl, 1);
      chk("tbl_we", MemWe, !vt[i].rej);
      if (!vt[i].rej) begin
        chk("tbl_data", MemData, vt[i].word);
        chk("tbl_addr", MemAddr, 0);
      end
      chk("tbl_err", Error, vt[i].rej);
      chk("tbl_done", Done, 1);
      chk("tbl_count", Count, !vt[i].rej);
    end

    ops = '{0, 63, 17};
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2, 5, ops[i], 0, i == 2);
      chk("b2b_we", MemWe, 1);
      chk("b2b_addr", MemAddr, i);
      chk("b2b_data", MemData, 5 * 64 + ops[i]);
    end
    chk("b2b_count", Count, 3);
    chk("b2b_err", Error, 0);
    chk("b2b_done", Done, 1);

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 1, 7, 0, 0);
    cyc(0, 1, 2, 2, 8, 0, 0);
    Reset_n = 0;
    #1;
    chk_zero("midrst");
    m_reset();
    @(posedge Clock); #1;
    Reset_n = 1;
    cyc(0, 1, 2, 3, 9, 0, 0);
    cyc(1, 1, 2, 3, 9, 0, 0);
    cyc(0, 1, 2, 4, 10, 0, 1);
    chk("restart_addr", MemAddr, 0);
    chk("restart_we", MemWe, 1);

    d4_Start = 1;
    @(posedge Clock); #1;
    d4_Start = 0; d4_InValid = 1; d4_Format = 2'd2; d4_Opcode = 4'd6;
    for (int k = 0; k < 5; k++) begin
      d4_Operand = 16'(k + 1);
      #1;
      chk("d4_ready", d4_InReady, k < 4);
      @(posedge Clock); #1;
      chk("d4_we", d4_MemWe, k < 4);
      if (k < 4) begin
        chk("d4_addr", d4_MemAddr, k);
        chk("d4_data", d4_MemData, 6 * 64 + k + 1);
      end
      chk("d4_count", d4_Count, (k < 4) ? k + 1 : 4);
      chk("d4_done", d4_Done, k >= 3);
    end
    d4_InValid = 0;
    chk("d4_err", d4_Error, 0);

    for (int n = 0; n < 600; n++) begin
      int operand;
      operand = ($urandom % 2) ? int'($urandom % 64)
                               : int'($urandom % 65536);
      cyc(($urandom % 100) < 6, ($urandom % 100) < 65,
          int'($urandom % 4), int'($urandom % 16), operand,
          int'($urandom % 4), ($urandom % 100) < 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
